mdrp_arbiter: RTL and testbench
===============================

MDRP_ARBITER -- requirements
Module: mdrp_arbiter

Interface
REQ-001 SHALL have parameter MD_RD_LAT, default 1, meaning cycles from OPC=2'b10 issued to I_MD_RD_DATA valid (legal 1..3).
REQ-002 SHALL have port I_MD_CLK  input  1  MDRP clock; the only clock; all logic rising-edge.
REQ-003 SHALL have port I_RST_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports I_REQ0_VLD / I_REQ1_VLD  input  1  each  requester n holds a transaction.
REQ-005 SHALL have ports O_REQ0_RDY / O_REQ1_RDY  output  1  each  accept strobe for requester n.
REQ-006 SHALL have ports I_REQn_ADDR, I_REQn_MASK, I_REQn_DATA  input  8 each  target register, write-bit mask, write data.
REQ-007 SHALL have ports O_RSP0_VLD / O_RSP1_VLD  output  1  each  one-cycle completion pulse for requester n.
REQ-008 SHALL have port O_RSP_DATA  output  8  register value read before modification.
REQ-009 SHALL have port O_RSP_ERR  output  1  readback mismatch; valid with O_RSPn_VLD.
REQ-010 SHALL have ports O_MD_INC  output  1, O_MD_OPC  output  2, O_MD_WR_DATA  output  8, I_MD_RD_DATA  input  8  MDRP port.
REQ-011 SHALL have port O_BUSY  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL encode MDRP opcodes as 2'b00 address-clear, 2'b10 read, 2'b01 write; O_MD_OPC=2'b10 whenever not clearing or writing.
REQ-013 SHALL implement states IDLE, CLR, SEEK, RD, CAPT, WR, VRD, VCHK, DONE.
REQ-014 SHALL drive O_REQn_RDY combinationally = IDLE & I_REQn_VLD & grant n; request fields latched on VLD&RDY.
REQ-015 SHALL arbitrate round-robin: both valid -> grant the requester not served last; last-served pointer resets to 1 (REQ0 wins first contest).
REQ-016 SHALL hold a tracked 8-bit address plus an addr_known flag, cleared by reset.
REQ-017 SHALL on accept go to CLR if ~addr_known or target < tracked address, else SEEK.
REQ-018 SHALL in CLR drive OPC=2'b00 for exactly one cycle, set tracked address 0, addr_known=1, then go SEEK.
REQ-019 SHALL in SEEK pulse O_MD_INC one cycle per step, incrementing tracked address, until equal to target; equal on entry -> RD next cycle with no INC.
REQ-020 SHALL in RD wait MD_RD_LAT cycles, then CAPT samples I_MD_RD_DATA into O_RSP_DATA.
REQ-021 SHALL skip WR when mask==8'h00 (pure read) and go DONE.
REQ-022 SHALL in WR drive O_MD_WR_DATA=(rd & ~mask)|(data & mask) and OPC=2'b01 for exactly one cycle.
REQ-023 SHALL in DONE pulse O_RSPn_VLD of the granted requester for one cycle, then IDLE; earliest re-accept is the cycle after DONE.
REQ-024 SHALL never wrap the tracked address past 8'hFF; target 8'hFF reached by 255 INCs from 0.
REQ-025 SHALL keep O_RSP_DATA and O_RSP_ERR stable until the next CAPT.

Reset
REQ-026 SHALL on I_RST_N=0 at a clock edge force IDLE, O_MD_INC=0, O_MD_OPC=2'b10, O_MD_WR_DATA=0, O_RSP_DATA=0, O_RSP_ERR=0, O_RSPn_VLD=0, O_REQn_RDY=0, O_BUSY=0, addr_known=0.
REQ-027 SHALL abort an in-flight transaction on reset with no O_RSPn_VLD; next transaction starts with CLR.

Configuration
REQ-028 SHALL, with MDRP_READBACK_EN defined, follow WR with VRD (read, MD_RD_LAT wait) and VCHK comparing I_MD_RD_DATA to written value, setting O_RSP_ERR=1 on mismatch, then DONE.
REQ-029 SHALL, without MDRP_READBACK_EN, go WR -> DONE directly with O_RSP_ERR tied 0.

Verification
REQ-030 SHALL cover reset then REQ0 addr=8'h0B mask=8'h3F data=8'h01, model reg=8'hC4 -> one CLR, 11 INC pulses, write 8'hC1, RSP0 pulse, RSP_DATA=8'hC4.
REQ-031 SHALL cover both VLD same cycle twice in a row -> grants REQ0, REQ1, then REQ0; never two RSP pulses in one cycle.
REQ-032 SHALL cover addr 8'h11 then 8'h12 -> second transaction: no CLR, exactly 1 INC; then 8'h0C -> CLR then 12 INCs.
REQ-033 SHALL cover mask=8'h00 at addr 8'hFF -> 255 INCs, no OPC=2'b01 cycle, RSP_DATA = model value.
REQ-034 SHALL cover MDRP_READBACK_EN with model ignoring writes at 8'h0C, write 8'hE0/mask 8'hE0 -> O_RSP_ERR=1 with RSP pulse; without macro -> ERR=0.
REQ-035 SHALL cover I_RST_N low during SEEK -> no RSP pulse, outputs at reset values next cycle, next request begins with CLR.

Source files
------------

// File: rtl/mdrp_arbiter_if.sv
// Requester-side bundle of the MDRP arbiter: two request channels plus the shared response.
// The arbiter uses the slave modport and requesters use the master modport.
interface mdrp_arbiter_if;
    logic       I_REQ0_VLD;
    logic       I_REQ1_VLD;
    logic [7:0] I_REQ0_ADDR;
    logic [7:0] I_REQ0_MASK;
    logic [7:0] I_REQ0_DATA;
    logic [7:0] I_REQ1_ADDR;
    logic [7:0] I_REQ1_MASK;
    logic [7:0] I_REQ1_DATA;
    logic       O_REQ0_RDY;
    logic       O_REQ1_RDY;
    logic       O_RSP0_VLD;
    logic       O_RSP1_VLD;
    logic [7:0] O_RSP_DATA;
    logic       O_RSP_ERR;

    modport master (
        output I_REQ0_VLD, I_REQ1_VLD,
        output I_REQ0_ADDR, I_REQ0_MASK, I_REQ0_DATA,
        output I_REQ1_ADDR, I_REQ1_MASK, I_REQ1_DATA,
        input  O_REQ0_RDY, O_REQ1_RDY,
        input  O_RSP0_VLD, O_RSP1_VLD, O_RSP_DATA, O_RSP_ERR
    );

    modport slave (
        input  I_REQ0_VLD, I_REQ1_VLD,
        input  I_REQ0_ADDR, I_REQ0_MASK, I_REQ0_DATA,
        input  I_REQ1_ADDR, I_REQ1_MASK, I_REQ1_DATA,
        output O_REQ0_RDY, O_REQ1_RDY,
        output O_RSP0_VLD, O_RSP1_VLD, O_RSP_DATA, O_RSP_ERR
    );
endinterface

// File: rtl/mdrp_arbiter.sv
// Round-robin arbiter giving two requesters read-modify-write access to an auto-incrementing MDRP port.
// Define MDRP_READBACK_EN to re-read every written register and report mismatches on O_RSP_ERR.
module mdrp_arbiter #(
    parameter int MD_RD_LAT = 1
) (
    input  logic          I_MD_CLK,
    input  logic          I_RST_N,
    mdrp_arbiter_if.slave bus,
    output logic          O_MD_INC,
    output logic [1:0]    O_MD_OPC,
    output logic [7:0]    O_MD_WR_DATA,
    input  logic [7:0]    I_MD_RD_DATA,
    output logic          O_BUSY
);
    localparam logic [1:0] OPC_CLR  = 2'b00;
    localparam logic [1:0] OPC_WR   = 2'b01;
    localparam logic [1:0] OPC_RD   = 2'b10;
    localparam logic [1:0] LAT_LAST = 2'(MD_RD_LAT - 1);

    typedef enum logic [3:0] {
        IDLE, CLR, SEEK, RD, CAPT, WR, VRD, VCHK, DONE
    } state_t;

    state_t     state;
    state_t     nextState;
    logic [7:0] trackAddr;
    logic       addrKnown;
    logic       lastServed;
    logic       grant;
    logic [7:0] tgtAddr;
    logic [7:0] tgtMask;
    logic [7:0] tgtData;
    logic [7:0] rspData;
    logic [1:0] latCnt;
    logic       latDone;
    logic       pickReq1;
    logic       accept0;
    logic       accept1;
    logic       accept;
    logic [7:0] reqAddr;
    logic [7:0] wrValue;

    // Requester 1 wins when alone, or when both are valid and requester 0 was served last.
    assign pickReq1 = bus.I_REQ1_VLD & (~bus.I_REQ0_VLD | ~lastServed);
    assign accept0  = I_RST_N & (state == IDLE) & bus.I_REQ0_VLD & ~pickReq1;
    assign accept1  = I_RST_N & (state == IDLE) & pickReq1;
    assign accept   = accept0 | accept1;
    assign reqAddr  = pickReq1 ? bus.I_REQ1_ADDR : bus.I_REQ0_ADDR;

    assign bus.O_REQ0_RDY = accept0;
    assign bus.O_REQ1_RDY = accept1;
    assign bus.O_RSP0_VLD = (state == DONE) & ~grant;
    assign bus.O_RSP1_VLD = (state == DONE) & grant;
    assign bus.O_RSP_DATA = rspData;
    assign O_BUSY         = (state != IDLE);

    assign latDone = (latCnt == LAT_LAST);
    assign wrValue = (rspData & ~tgtMask) | (tgtData & tgtMask);

    always_ff @(posedge I_MD_CLK) begin
        if (!I_RST_N) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        O_MD_INC     = 1'b0;
        O_MD_OPC     = OPC_RD;
        O_MD_WR_DATA = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = (!addrKnown || (reqAddr < trackAddr)) ? CLR : SEEK;
                end
            end
            CLR: begin
                O_MD_OPC  = OPC_CLR;
                nextState = SEEK;
            end
            SEEK: begin
                if (trackAddr == tgtAddr) begin
                    nextState = RD;
                end else begin
                    O_MD_INC = 1'b1;
                end
            end
            RD: begin
                if (latDone) begin
                    nextState = CAPT;
                end
            end
            CAPT: begin
                nextState = (tgtMask == 8'h00) ? DONE : WR;
            end
            WR: begin
                O_MD_OPC     = OPC_WR;
                O_MD_WR_DATA = wrValue;
`ifdef MDRP_READBACK_EN
                nextState    = VRD;
`else
                nextState    = DONE;
`endif
            end
            VRD: begin
                if (latDone) begin
                    nextState = VCHK;
                end
            end
            VCHK: begin
                nextState = DONE;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // The tracked address mirrors the port's internal pointer; it only ever counts up toward the target.
    always_ff @(posedge I_MD_CLK) begin
        if (!I_RST_N) begin
            addrKnown  <= 1'b0;
            trackAddr  <= '0;
            lastServed <= 1'b1;
            grant      <= 1'b0;
            tgtAddr    <= '0;
            tgtMask    <= '0;
            tgtData    <= '0;
            latCnt     <= '0;
            rspData    <= '0;
        end else begin
            if (accept) begin
                grant      <= pickReq1;
                lastServed <= pickReq1;
                tgtAddr    <= reqAddr;
                tgtMask    <= pickReq1 ? bus.I_REQ1_MASK : bus.I_REQ0_MASK;
                tgtData    <= pickReq1 ? bus.I_REQ1_DATA : bus.I_REQ0_DATA;
            end
            if (state == CLR) begin
                trackAddr <= '0;
                addrKnown <= 1'b1;
            end else if (O_MD_INC) begin
                trackAddr <= trackAddr + 8'd1;
            end
            if (((state == RD) || (state == VRD)) && !latDone) begin
                latCnt <= latCnt + 2'd1;
            end else begin
                latCnt <= '0;
            end
            if (state == CAPT) begin
                rspData <= I_MD_RD_DATA;
            end
        end
    end

`ifdef MDRP_READBACK_EN
    logic rspErr;

    // The error flag belongs to the transaction captured last, so each capture starts it clean.
    always_ff @(posedge I_MD_CLK) begin
        if (!I_RST_N) begin
            rspErr <= 1'b0;
        end else if (state == CAPT) begin
            rspErr <= 1'b0;
        end else if (state == VCHK) begin
            rspErr <= (I_MD_RD_DATA != wrValue);
        end
    end

    assign bus.O_RSP_ERR = rspErr;
`else
    assign bus.O_RSP_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_mdrp_arbiter.sv
// Bench for mdrp_arbiter: an MDRP register-file device plus a transaction-level reference model.
// Register 8'h0C of the device ignores writes, so readback builds must flag it.
`timescale 1ns/1ps
module tb_mdrp_arbiter;
    localparam int LAT    = 2;
    localparam int BUDGET = 3000;
`ifdef MDRP_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic       clk  = 1'b0;
    logic       rstN = 1'b0;
    logic       mdInc;
    logic [1:0] mdOpc;
    logic [7:0] mdWrData;
    logic [7:0] mdRdData;
    logic       busy;

    mdrp_arbiter_if bus ();

    mdrp_arbiter #(.MD_RD_LAT(LAT)) dut (
        .I_MD_CLK    (clk),
        .I_RST_N     (rstN),
        .bus         (bus),
        .O_MD_INC    (mdInc),
        .O_MD_OPC    (mdOpc),
        .O_MD_WR_DATA(mdWrData),
        .I_MD_RD_DATA(mdRdData),
        .O_BUSY      (busy)
    );

    always #5 clk = ~clk;

    int vectorsApplied = 0;
    int miscompares    = 0;

    // Device side: pointer that clears/increments, read data only valid LAT cycles into a read.
    logic [7:0] devRegs [256];
    logic [7:0] devAddr = 8'h37;
    int         devAge  = 0;

    always @(posedge clk) begin
        if (mdOpc == 2'b00) devAddr <= 8'h00;
        else if (mdInc)     devAddr <= devAddr + 8'd1;
        if (mdOpc == 2'b01 && devAddr != 8'h0C) devRegs[devAddr] <= mdWrData;
        if (mdOpc == 2'b10 && !mdInc) devAge <= (devAge < 100) ? devAge + 1 : devAge;
        else                          devAge <= 0;
    end

    assign mdRdData = (devAge >= LAT) ? devRegs[devAddr] : ~devRegs[devAddr];

    // Reference model state: register contents, tracked address, arbitration pointer.
    logic [7:0] refMem [256];
    bit         refKnown = 1'b0;
    logic [7:0] refTracked = 8'h00;
    bit         refLast = 1'b1;
    bit         inFlight = 1'b0;
    bit         resetCheck = 1'b0;
    logic [7:0] heldData = 8'h00;
    bit         heldErr = 1'b0;
    bit         expReq;
    logic [7:0] expAddr, expOld, expWrVal, expRspData;
    logic [7:0] accMask, accData;
    bit         expClr, expWr, expErr, e0, e1;
    int         expIncs;
    int         clrSeen, incSeen, wrSeen;
    int         doneCount = 0;
    int         lastClr, lastIncs, lastWrSeen;
    logic [7:0] lastWrVal, lastRspData;
    logic       lastErr;
    int         grantLog [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (resetCheck) begin
            checkOutput("rstInc", mdInc, 0);
            checkOutput("rstOpc", mdOpc, 2'b10);
            checkOutput("rstWrData", mdWrData, 0);
            checkOutput("rstRspData", bus.O_RSP_DATA, 0);
            checkOutput("rstRspErr", bus.O_RSP_ERR, 0);
            checkOutput("rstRsp0", bus.O_RSP0_VLD, 0);
            checkOutput("rstRsp1", bus.O_RSP1_VLD, 0);
            checkOutput("rstBusy", busy, 0);
            resetCheck = 1'b0;
        end
        if (!rstN) begin
            checkOutput("rdy0InReset", bus.O_REQ0_RDY, 0);
            checkOutput("rdy1InReset", bus.O_REQ1_RDY, 0);
            inFlight   = 1'b0;
            refKnown   = 1'b0;
            refLast    = 1'b1;
            heldData   = 8'h00;
            heldErr    = 1'b0;
            resetCheck = 1'b1;
        end else begin
            e0 = !inFlight && bus.I_REQ0_VLD && (!bus.I_REQ1_VLD || refLast);
            e1 = !inFlight && bus.I_REQ1_VLD && (!bus.I_REQ0_VLD || !refLast);
            checkOutput("rdy0", bus.O_REQ0_RDY, e0);
            checkOutput("rdy1", bus.O_REQ1_RDY, e1);
            checkOutput("busy", busy, inFlight);
            if (!inFlight) begin
                checkOutput("idleOpc", mdOpc, 2'b10);
                checkOutput("idleInc", mdInc, 0);
                checkOutput("idleWrData", mdWrData, 0);
                checkOutput("idleRsp0", bus.O_RSP0_VLD, 0);
                checkOutput("idleRsp1", bus.O_RSP1_VLD, 0);
                checkOutput("heldRspData", bus.O_RSP_DATA, heldData);
                checkOutput("heldRspErr", bus.O_RSP_ERR, heldErr);
            end else begin
                if (mdOpc == 2'b00) clrSeen++;
                if (mdInc) incSeen++;
                if (mdOpc == 2'b01) begin
                    wrSeen++;
                    lastWrVal = mdWrData;
                    checkOutput("wrData", mdWrData, expWrVal);
                    checkOutput("wrAddr", devAddr, expAddr);
                end
                if (bus.O_RSP0_VLD || bus.O_RSP1_VLD) begin
                    checkOutput("rspOneHot", bus.O_RSP0_VLD & bus.O_RSP1_VLD, 0);
                    checkOutput("rspRequester", bus.O_RSP1_VLD, expReq);
                    checkOutput("rspData", bus.O_RSP_DATA, expRspData);
                    checkOutput("rspErr", bus.O_RSP_ERR, expErr);
                    checkOutput("clrCount", clrSeen, expClr);
                    checkOutput("incCount", incSeen, expIncs);
                    checkOutput("wrCount", wrSeen, expWr);
                    lastClr     = clrSeen;
                    lastIncs    = incSeen;
                    lastWrSeen  = wrSeen;
                    lastRspData = bus.O_RSP_DATA;
                    lastErr     = bus.O_RSP_ERR;
                    grantLog.push_back(int'(bus.O_RSP1_VLD));
                    if (expWr && expAddr != 8'h0C) refMem[expAddr] = expWrVal;
                    heldData = expRspData;
                    heldErr  = expErr;
                    inFlight = 1'b0;
                    doneCount++;
                end
            end
            if (e0 || e1) begin
                expReq     = e1;
                expAddr    = e1 ? bus.I_REQ1_ADDR : bus.I_REQ0_ADDR;
                accMask    = e1 ? bus.I_REQ1_MASK : bus.I_REQ0_MASK;
                accData    = e1 ? bus.I_REQ1_DATA : bus.I_REQ0_DATA;
                expClr     = !refKnown || (expAddr < refTracked);
                expIncs    = expClr ? int'(expAddr) : int'(expAddr) - int'(refTracked);
                expOld     = refMem[expAddr];
                expWrVal   = (expOld & ~accMask) | (accData & accMask);
                expWr      = (accMask != 8'h00);
                expErr     = READBACK && expWr && (expAddr == 8'h0C) && (expWrVal != expOld);
                expRspData = expOld;
                refTracked = expAddr;
                refKnown   = 1'b1;
                refLast    = e1;
                inFlight   = 1'b1;
                clrSeen    = 0;
                incSeen    = 0;
                wrSeen     = 0;
            end
        end
    end

    // Presents one transaction on each selected requester and waits for all of them to complete.
    task automatic applyStimulus(input bit v0, input logic [7:0] a0, input logic [7:0] m0, input logic [7:0] d0,
                                 input bit v1, input logic [7:0] a1, input logic [7:0] m1, input logic [7:0] d1);
        int  target;
        int  budget;
        bit  acc0;
        bit  acc1;
        target = doneCount + int'(v0) + int'(v1);
        @(posedge clk); #1;
        bus.I_REQ0_VLD  = v0;
        bus.I_REQ0_ADDR = a0;
        bus.I_REQ0_MASK = m0;
        bus.I_REQ0_DATA = d0;
        bus.I_REQ1_VLD  = v1;
        bus.I_REQ1_ADDR = a1;
        bus.I_REQ1_MASK = m1;
        bus.I_REQ1_DATA = d1;
        budget = 0;
        while ((bus.I_REQ0_VLD || bus.I_REQ1_VLD || doneCount < target) && budget < BUDGET) begin
            @(negedge clk);
            acc0 = bus.I_REQ0_VLD && bus.O_REQ0_RDY;
            acc1 = bus.I_REQ1_VLD && bus.O_REQ1_RDY;
            @(posedge clk); #1;
            if (acc0) bus.I_REQ0_VLD = 1'b0;
            if (acc1) bus.I_REQ1_VLD = 1'b0;
            budget++;
        end
        bus.I_REQ0_VLD = 1'b0;
        bus.I_REQ1_VLD = 1'b0;
        checkOutput("txnCompleted", doneCount >= target, 1);
    endtask

    initial begin
        int doneBefore;
        int n;
        bit v0;
        bit v1;
        logic [7:0] a;
        logic [7:0] m;

        for (int i = 0; i < 256; i++) devRegs[i] = 8'(i * 37 + 5);
        devRegs[8'h0B] = 8'hC4;
        devRegs[8'h0C] = 8'h15;
        for (int i = 0; i < 256; i++) refMem[i] = devRegs[i];
        bus.I_REQ0_VLD  = 1'b0;
        bus.I_REQ1_VLD  = 1'b0;
        bus.I_REQ0_ADDR = 8'h00;
        bus.I_REQ0_MASK = 8'h00;
        bus.I_REQ0_DATA = 8'h00;
        bus.I_REQ1_ADDR = 8'h00;
        bus.I_REQ1_MASK = 8'h00;
        bus.I_REQ1_DATA = 8'h00;
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;

        applyStimulus(1'b1, 8'h0B, 8'h3F, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00);
        checkOutput("pin0BClr", lastClr, 1);
        checkOutput("pin0BInc", lastIncs, 11);
        checkOutput("pin0BWrVal", lastWrVal, 8'hC1);
        checkOutput("pin0BRsp", lastRspData, 8'hC4);
        checkOutput("pin0BGrant", grantLog[$], 0);

        applyStimulus(1'b1, 8'h11, 8'hF0, 8'hA5, 1'b0, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b1, 8'h12, 8'h0F, 8'h3C, 1'b0, 8'h00, 8'h00, 8'h00);
        checkOutput("pin12Clr", lastClr, 0);
        checkOutput("pin12Inc", lastIncs, 1);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h0C, 8'h00, 8'h00);
        checkOutput("pin0CClr", lastClr, 1);
        checkOutput("pin0CInc", lastIncs, 12);
        checkOutput("pin0CRsp", lastRspData, 8'h15);

        applyStimulus(1'b1, 8'h20, 8'h81, 8'h7E, 1'b1, 8'h30, 8'hFF, 8'h99);
        applyStimulus(1'b1, 8'h28, 8'h00, 8'h00, 1'b1, 8'h31, 8'h18, 8'h66);
        n = grantLog.size();
        checkOutput("pinPairGrant0", grantLog[n-4], 0);
        checkOutput("pinPairGrant1", grantLog[n-3], 1);
        checkOutput("pinPairGrant2", grantLog[n-2], 0);
        checkOutput("pinPairGrant3", grantLog[n-1], 1);

        // Abort a transaction while it is still stepping the port pointer.
        doneBefore = doneCount;
        @(posedge clk); #1;
        bus.I_REQ0_VLD  = 1'b1;
        bus.I_REQ0_ADDR = 8'h80;
        bus.I_REQ0_MASK = 8'hFF;
        bus.I_REQ0_DATA = 8'h5A;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.O_REQ0_RDY) break;
        end
        @(posedge clk); #1 bus.I_REQ0_VLD = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mdInc) break;
        end
        checkOutput("seekBeforeReset", mdInc, 1);
        @(posedge clk); #1 rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        repeat (5) @(posedge clk);
        checkOutput("abortNoRsp", doneCount - doneBefore, 0);

        applyStimulus(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        checkOutput("pinFFClr", lastClr, 1);
        checkOutput("pinFFInc", lastIncs, 255);
        checkOutput("pinFFWr", lastWrSeen, 0);
        checkOutput("pinFFRsp", lastRspData, 8'hE0);

        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h0C, 8'hE0, 8'hE0);
        checkOutput("pinReadbackErr", lastErr, READBACK);
        checkOutput("pinReadbackRsp", lastRspData, 8'h15);

        for (int t = 0; t < 40; t++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 60));
            m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            applyStimulus(v0, a, m, 8'($urandom), v1, 8'($urandom_range(0, 60)),
                          ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 8'($urandom));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end
endmodule
